// File: rtl/ext_trigger_sequencer.sv
// ext_trigger_sequencer
//
// Generates a programmed burst of external-trigger pulses aligned to clk, for
// driving the LArPix external_trigger pin from a bench or the MCP. A burst is an
// optional initial delay followed by num_trig pulses. Each pulse is width cycles
// high, and consecutive rising edges are period cycles apart. All outputs are
// registered.
//
// Parameters
//   CNT_BITS  width of the delay / width / period fields (clock cycles)
//   NUM_BITS  width of the pulse-count field and of trig_count
//
// Ports
//   clk               system clock, rising edge
//   reset             synchronous active-high reset
//   start             begin a burst (sampled only when idle)
//   abort             terminate a running burst on the next edge
//   init_delay        cycles from start acceptance to the first rise (0 allowed)
//   width             high time per pulse, >= 1
//   period            rise-to-rise spacing, > width
//   num_trig          pulses per burst, >= 1
//   external_trigger  registered trigger output
//   trig_strobe       one-cycle pulse with each rising edge of external_trigger
//   trig_count        pulses issued in the current or last burst
//   busy              high while a burst is running
//   done              one-cycle pulse on normal completion
//   aborted           one-cycle pulse when an abort takes effect
//   config_err        one-cycle pulse when a start is rejected

module ext_trigger_sequencer #(
  parameter int unsigned CNT_BITS = 16,
  parameter int unsigned NUM_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [CNT_BITS-1:0] init_delay,
  input  logic [CNT_BITS-1:0] width,
  input  logic [CNT_BITS-1:0] period,
  input  logic [NUM_BITS-1:0] num_trig,
  output logic                external_trigger,
  output logic                trig_strobe,
  output logic [NUM_BITS-1:0] trig_count,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic                config_err
);

  localparam logic [CNT_BITS-1:0] CntZero = '0;
  localparam logic [CNT_BITS-1:0] CntOne  = {{(CNT_BITS-1){1'b0}}, 1'b1};
  localparam logic [NUM_BITS-1:0] NumZero = '0;
  localparam logic [NUM_BITS-1:0] NumOne  = {{(NUM_BITS-1){1'b0}}, 1'b1};
  localparam logic [NUM_BITS-1:0] NumMax  = '1;

  typedef enum logic [1:0] {
    StIdle,
    StDelay,
    StHigh,
    StLow
  } state_e;

  state_e state_q, state_d;

  // Shared down-counter: holds the remaining cycles minus one of the current
  // phase, so a phase ends on the edge where it is sampled at zero.
  logic [CNT_BITS-1:0] cnt_q, cnt_d;

  // Shadow copies of the configuration, captured at acceptance so that input
  // changes during a burst have no effect. The LOW length is precomputed here.
  logic [CNT_BITS-1:0] high_m1_q, high_m1_d;
  logic [CNT_BITS-1:0] low_m1_q, low_m1_d;
  logic [NUM_BITS-1:0] num_q, num_d;

  // Registered outputs.
  logic                trig_q, trig_d;
  logic                strobe_q, strobe_d;
  logic [NUM_BITS-1:0] count_q, count_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                aborted_q, aborted_d;
  logic                err_q, err_d;

  logic                cfg_bad;
  logic [NUM_BITS-1:0] count_inc;

  assign cfg_bad = (width == CntZero) || (period <= width) || (num_trig == NumZero);

  // Saturating increment. The saturation is unreachable with a legal config,
  // since num_trig bounds the count, but it keeps the counter from wrapping.
  assign count_inc = (count_q == NumMax) ? count_q : count_q + NumOne;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    high_m1_d = high_m1_q;
    low_m1_d  = low_m1_q;
    num_d     = num_q;
    trig_d    = trig_q;
    strobe_d  = 1'b0;
    count_d   = count_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        trig_d = 1'b0;
        // abort in idle has no effect of its own, but it suppresses a start
        if (start && !abort) begin
          if (cfg_bad) begin
            err_d = 1'b1;
          end else begin
            high_m1_d = width - CntOne;
            low_m1_d  = period - width - CntOne;
            num_d     = num_trig;
            if (init_delay == CntZero) begin
              // Zero delay: the first pulse rises on the very next edge.
              state_d  = StHigh;
              cnt_d    = width - CntOne;
              trig_d   = 1'b1;
              strobe_d = 1'b1;
              count_d  = NumOne;
            end else begin
              state_d = StDelay;
              cnt_d   = init_delay - CntOne;
              count_d = NumZero;
            end
          end
        end
      end

      StDelay: begin
        if (cnt_q == CntZero) begin
          state_d  = StHigh;
          cnt_d    = high_m1_q;
          trig_d   = 1'b1;
          strobe_d = 1'b1;
          count_d  = count_inc;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end

      StHigh: begin
        if (cnt_q == CntZero) begin
          trig_d = 1'b0;
          if (count_q == num_q) begin
            // done coincides with the falling edge of the last pulse
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            state_d = StLow;
            cnt_d   = low_m1_q;
          end
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end

      StLow: begin
        if (cnt_q == CntZero) begin
          state_d  = StHigh;
          cnt_d    = high_m1_q;
          trig_d   = 1'b1;
          strobe_d = 1'b1;
          count_d  = count_inc;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end

      default: begin
        state_d = StIdle;
        trig_d  = 1'b0;
      end
    endcase

    // Abort overrides everything a running burst would otherwise do on this
    // edge, including a completion; the pulse count is frozen where it is.
    if (abort && (state_q != StIdle)) begin
      state_d   = StIdle;
      trig_d    = 1'b0;
      strobe_d  = 1'b0;
      done_d    = 1'b0;
      aborted_d = 1'b1;
      count_d   = count_q;
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= CntZero;
      high_m1_q <= CntZero;
      low_m1_q  <= CntZero;
      num_q     <= NumZero;
      trig_q    <= 1'b0;
      strobe_q  <= 1'b0;
      count_q   <= NumZero;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      high_m1_q <= high_m1_d;
      low_m1_q  <= low_m1_d;
      num_q     <= num_d;
      trig_q    <= trig_d;
      strobe_q  <= strobe_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      err_q     <= err_d;
    end
  end

  assign external_trigger = trig_q;
  assign trig_strobe      = strobe_q;
  assign trig_count       = count_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign aborted          = aborted_q;
  assign config_err       = err_q;

endmodule

// File: tb/tb_ext_trigger_sequencer.sv
// Self-checking bench for ext_trigger_sequencer. Expected outputs for every cycle
// of a burst come from the closed-form timing rules (rise at 1+D+k*P, high for W
// cycles, done at 1+D+(N-1)*P+W), evaluated with plain arithmetic.
module tb_ext_trigger_sequencer;

  localparam int CW = 16;
  localparam int NW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic [CW-1:0] init_delay;
  logic [CW-1:0] width;
  logic [CW-1:0] period;
  logic [NW-1:0] num_trig;
  logic          external_trigger;
  logic          trig_strobe;
  logic [NW-1:0] trig_count;
  logic          busy;
  logic          done;
  logic          aborted;
  logic          config_err;

  int checks = 0;
  int passes = 0;
  int fails = 0;
  int model_count = 0;

  always #5 clk = ~clk;

  ext_trigger_sequencer #(
    .CNT_BITS(CW),
    .NUM_BITS(NW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .abort           (abort),
    .init_delay      (init_delay),
    .width           (width),
    .period          (period),
    .num_trig        (num_trig),
    .external_trigger(external_trigger),
    .trig_strobe     (trig_strobe),
    .trig_count      (trig_count),
    .busy            (busy),
    .done            (done),
    .aborted         (aborted),
    .config_err      (config_err)
  );

  task automatic chk(input string tag, input int rel, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s at cycle %0d: observed %0d, expected %0d", tag, rel, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int rel, input int e_trig,
                           input int e_strobe, input int e_count, input int e_busy,
                           input int e_done, input int e_abort, input int e_err);
    chk({tag, ".trigger"}, rel, 32'(external_trigger), 32'(e_trig));
    chk({tag, ".strobe"}, rel, 32'(trig_strobe), 32'(e_strobe));
    chk({tag, ".count"}, rel, 32'(trig_count), 32'(e_count));
    chk({tag, ".busy"}, rel, 32'(busy), 32'(e_busy));
    chk({tag, ".done"}, rel, 32'(done), 32'(e_done));
    chk({tag, ".aborted"}, rel, 32'(aborted), 32'(e_abort));
    chk({tag, ".config_err"}, rel, 32'(config_err), 32'(e_err));
  endtask

  // Pulses whose rising edge has occurred by cycle rel after acceptance.
  function automatic int pulses_by(input int rel, input int d, input int p, input int n);
    int k;
    if (rel < 1 + d) return 0;
    k = (rel - 1 - d) / p + 1;
    return (k > n) ? n : k;
  endfunction

  // Runs one legal burst, checking every output every cycle. abort_eff / reset_eff
  // are the cycles (relative to acceptance) at which an abort or reset should be
  // visible on the outputs; 0 means none. noisy scribbles on start and the config
  // inputs while the burst runs. Called and returns at a negedge.
  task automatic run_burst(input string tag, input int d, input int w, input int p,
                           input int n, input int abort_eff, input int reset_eff,
                           input bit noisy);
    int done_rel, last, k, off;
    int e_trig, e_strobe, e_count, e_busy, e_done, e_abort;
    done_rel = 1 + d + (n - 1) * p + w;
    last = (abort_eff > 0) ? abort_eff : ((reset_eff > 0) ? reset_eff : done_rel);
    init_delay = CW'(d);
    width      = CW'(w);
    period     = CW'(p);
    num_trig   = NW'(n);
    start      = 1'b1;
    abort      = 1'b0;
    for (int rel = 1; rel <= last + 1; rel++) begin
      @(negedge clk);
      if (reset_eff > 0 && rel >= reset_eff) begin
        e_trig = 0; e_strobe = 0; e_count = 0; e_busy = 0; e_done = 0; e_abort = 0;
      end else if (abort_eff > 0 && rel >= abort_eff) begin
        e_trig = 0; e_strobe = 0; e_busy = 0; e_done = 0;
        e_count = pulses_by(abort_eff - 1, d, p, n);
        e_abort = (rel == abort_eff) ? 1 : 0;
      end else begin
        e_trig = 0; e_strobe = 0;
        if (rel >= 1 + d) begin
          k   = (rel - 1 - d) / p;
          off = (rel - 1 - d) % p;
          if (k < n && off < w) e_trig = 1;
          if (k < n && off == 0) e_strobe = 1;
        end
        e_count = pulses_by(rel, d, p, n);
        e_busy  = (rel < done_rel) ? 1 : 0;
        e_done  = (rel == done_rel) ? 1 : 0;
        e_abort = 0;
      end
      check_all(tag, rel, e_trig, e_strobe, e_count, e_busy, e_done, e_abort, 0);
      model_count = e_count;
      // Drive inputs for the next edge.
      start = (noisy && rel < last) ? 1'($urandom) : 1'b0;
      if (noisy) begin
        init_delay = CW'($urandom);
        width      = CW'($urandom);
        period     = CW'($urandom);
        num_trig   = NW'($urandom);
      end
      abort = (abort_eff > 0 && rel == abort_eff - 1);
      reset = (reset_eff > 0 && rel == reset_eff - 1);
    end
    start = 1'b0;
    abort = 1'b0;
    reset = 1'b0;
  endtask

  task automatic reject(input string tag, input int w, input int p, input int n);
    init_delay = CW'($urandom_range(0, 5));
    width      = CW'(w);
    period     = CW'(p);
    num_trig   = NW'(n);
    start      = 1'b1;
    @(negedge clk);
    check_all(tag, 1, 0, 0, model_count, 0, 0, 0, 1);
    start = 1'b0;
    @(negedge clk);
    check_all(tag, 2, 0, 0, model_count, 0, 0, 0, 0);
  endtask

  initial begin
    int d, w, p, n, ab, dr;
    reset      = 1'b1;
    start      = 1'b1;
    abort      = 1'b0;
    init_delay = '0;
    width      = CW'(2);
    period     = CW'(4);
    num_trig   = NW'(1);
    repeat (3) @(negedge clk);
    check_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check_all("post_reset", 0, 0, 0, 0, 0, 0, 0, 0);

    run_burst("basic", 0, 2, 4, 3, 0, 0, 1'b0);

    reject("bad_w0", 0, 4, 1);
    reject("bad_p_eq_w", 4, 4, 1);
    reject("bad_n0", 1, 4, 0);

    // Abort sampled on the edge after cycle 12, during the second pulse.
    run_burst("abort", 0, 3, 10, 5, 13, 0, 1'b1);

    // start and abort together while idle do nothing.
    init_delay = '0;
    width      = CW'(1);
    period     = CW'(2);
    num_trig   = NW'(2);
    start      = 1'b1;
    abort      = 1'b1;
    @(negedge clk);
    check_all("collide", 1, 0, 0, model_count, 0, 0, 0, 0);
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check_all("collide", 2, 0, 0, model_count, 0, 0, 0, 0);

    run_burst("reset_mid", 0, 2, 4, 3, 0, 6, 1'b0);
    run_burst("after_reset", 0, 1, 2, 2, 0, 0, 1'b0);
    run_burst("isolation", 3, 2, 5, 3, 0, 0, 1'b1);
    run_burst("min_delay", 1, 1, 2, 3, 0, 0, 1'b1);

    for (int i = 0; i < 12; i++) begin
      d  = $urandom_range(0, 5);
      w  = $urandom_range(1, 4);
      p  = $urandom_range(w + 1, w + 5);
      n  = $urandom_range(1, 4);
      dr = 1 + d + (n - 1) * p + w;
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(2, dr) : 0;
      run_burst("random", d, w, p, n, ab, 0, 1'b1);
    end

    for (int i = 0; i < 4; i++) begin
      w = $urandom_range(1, 10);
      unique case ($urandom_range(0, 2))
        0: reject("rand_bad_w", 0, $urandom_range(0, 10), $urandom_range(1, 9));
        1: reject("rand_bad_p", w, $urandom_range(0, w), $urandom_range(1, 9));
        default: reject("rand_bad_n", w, w + $urandom_range(1, 5), 0);
      endcase
    end

    run_burst("bench_equiv", 2000, 20, 2000, 20, 0, 0, 1'b1);
    chk("bench_equiv.final_count", 0, 32'(trig_count), 32'(20));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
